// File: rtl/blink_pkg.sv
// Shared types and default timing for the status-LED blink arbiter.
package blink_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} blink_state_t;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned TICK_DIV_100MS = CLK_HZ / 10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks after a clear.
module blink_tick_gen
  import blink_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_100MS
) (
  input  logic clk50m,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == CNT_MAX)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one status LED; plays a burst of blinks per grant,
// followed by a fixed dark gap.
module led_blink_arbiter
  import blink_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TICK_DIV  = TICK_DIV_100MS,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 3,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic                              clk50m,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][CNT_W-1:0]     req_count,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              done,
  output logic                              led
);

  localparam int unsigned ID_W      = $clog2(NUM_REQ);
  localparam int unsigned MAX_TICKS = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam int unsigned PH_W      = $clog2(MAX_TICKS + 1);

  blink_state_t     state_q;
  logic [ID_W-1:0]  rr_q, grant_q, winner;
  logic [CNT_W-1:0] remaining_q, rem_dec;
  logic [PH_W-1:0]  phase_q, phase_lim;
  logic             led_q, busy_q, done_q;
  logic             found, accept, tick, phase_end;
  int unsigned      idx;

  // Rotating priority search starting just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  assign accept = reset_n && (state_q == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    case (state_q)
      OFF:     phase_lim = PH_W'(OFF_TICKS - 1);
      GAP:     phase_lim = PH_W'(GAP_TICKS - 1);
      default: phase_lim = PH_W'(ON_TICKS - 1);
    endcase
  end

  assign phase_end = tick && (phase_q == phase_lim);
  assign rem_dec   = (remaining_q != '0) ? remaining_q - CNT_W'(1) : '0;

  blink_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk50m  (clk50m),
    .reset_n (reset_n),
    .clr     (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      grant_q     <= '0;
      rr_q        <= ID_W'(NUM_REQ - 1);
      remaining_q <= '0;
      phase_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            remaining_q <= req_count[winner];
            grant_q     <= winner;
            rr_q        <= winner;
            phase_q     <= '0;
            if (req_count[winner] == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ON;
              led_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ON, OFF, GAP: begin
          if (phase_end) begin
            phase_q <= '0;
            if (state_q == ON) begin
              remaining_q <= rem_dec;
              led_q       <= 1'b0;
              state_q     <= (rem_dec == '0) ? GAP : OFF;
            end else if (state_q == OFF) begin
              led_q   <= 1'b1;
              state_q <= ON;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (tick) begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign grant_id = grant_q;

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares the board's single status LED between several requesters. Each requester asks for a burst of N blinks; the block grants the LED round-robin and plays the burst at human-visible rates from clk50m. A fixed dark gap follows each burst. It sits between status sources (HPS bridge, error flags, heartbeat) and the LED pin, and supersedes a free-running blinker.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CNT_W, 4: width of the blink-count field.
- TICK_DIV, 5_000_000: clk50m cycles per tick (100 ms).
- ON_TICKS, 2: ticks the LED is lit per blink.
- OFF_TICKS, 3: ticks dark between blinks of one burst.
- GAP_TICKS, 10: ticks dark after a burst.

Ports:
- clk50m  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_count  in  NUM_REQ x CNT_W  blink count per requester.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- busy  out  1  burst or gap in progress.
- grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester.
- done  out  1  single-cycle pulse at the end of a burst.
- led  out  1  LED drive, high = lit.

## Operation
- States: IDLE, ON, OFF, GAP. busy = (state != IDLE). led = (state == ON).
- Reset values: state IDLE, led 0, busy 0, done 0, req_ready 0, grant_id 0, rr pointer NUM_REQ-1 (so requester 0 wins first).
- Arbitration happens only in IDLE. Search starts at rr pointer+1 modulo NUM_REQ. The first requester with valid set wins.
- req_ready is combinational: asserted for the winner only, only in IDLE.
- Accept cycle T is the cycle with req_ready high. In that cycle the block:
  - loads remaining = req_count[winner];
  - updates grant_id and the rr pointer to the winner;
  - clears the tick generator and the phase tick counter.
- A requester holds valid and count stable until ready. Dropping valid before accept is legal and leaves no side effects. Valid held after accept is treated as a new request next time IDLE is reached.
- count == 0: accepted, state stays IDLE, no blinks, no gap, done pulses at T+1.
- count > 0: IDLE→ON.
- ON ends after ON_TICKS ticks and decrements remaining. If the result is 0, go to GAP; otherwise go to OFF.
- OFF ends after OFF_TICKS ticks and goes to ON.
- GAP ends after GAP_TICKS ticks, goes to IDLE, and pulses done in the first IDLE cycle.
- The phase tick counter resets at every phase change.
- A new accept is allowed in the same cycle done is high.
- Arithmetic: remaining is CNT_W bits and only decrements when non-zero, so it cannot underflow. The tick counter is $clog2(TICK_DIV) bits and wraps from TICK_DIV-1 to 0.
- Reset mid-burst: led drops immediately (async), the burst is abandoned and not replayed.

## Timing
- The tick pulses when the divider count equals TICK_DIV-1, i.e. every TICK_DIV cycles after a clear.
- Each phase lasts exactly PHASE_TICKS*TICK_DIV cycles. The state changes on the cycle after the terminating tick.
- led rises at T+1.
- Burst length in cycles: count*ON_TICKS*TICK_DIV + (count-1)*OFF_TICKS*TICK_DIV + GAP_TICKS*TICK_DIV.
- done is registered, high in cycle T+1+burst length.
- Arbitration-to-ready latency: 0 cycles in IDLE.

## Structure
- Shared package blink_pkg holds:
  - enum blink_state_t {IDLE, ON, OFF, GAP};
  - the default-timing localparams (CLK_HZ = 50_000_000, TICK_DIV_100MS).
- One sub-module, blink_tick_gen (params TICK_DIV; ports clk50m, reset_n, clr, tick). It replaces the ad-hoc 28-bit downcounter pattern.
- The top level holds the arbiter, FSM, phase tick counter and remaining counter.

## Test plan
All scenarios use TICK_DIV=4, ON=2, OFF=3, GAP=10.
- Reset check: reset_n held low with valid asserted → led 0, ready 0, busy 0, grant_id 0. After release, requester 0 is accepted on the first clock.
- Single burst: req 1, count 2, accepted at T → led high T+1..T+8, low T+9..T+20, high T+21..T+28, low through T+68, done at T+69, busy low at T+69.
- Round-robin: all four valid continuously with count 1 → grants in order 0,1,2,3,0. Each grant comes on its done cycle, 49 cycles apart.
- Zero count: req 2, count 0 → ready at T, led stays 0, busy stays 0, done at T+1. The next request is accepted at T+1.
- Withdrawal and collision: req 3 valid for 2 cycles during a burst, then dropped → never granted. req 0 and req 3 raised in the same IDLE cycle after grant 3 → req 0 wins.
- Reset mid-burst: reset_n low during the second ON phase → led 0 within the same cycle, state IDLE. After release, a pending request is re-arbitrated from requester 0.
